// File: rtl/lvds_pkg.sv
// ---------------------------------------------------------------------------
// lvds_pkg
// Shared types and constants for the LVDS transmit streamer.
//   lvds_state_t       : transmit FSM state encoding (IDLE / SYNC / SEND)
//   DEFAULT_SYNC_WORD  : preamble sample sent at the start of every burst
//   beats_per_sample() : number of lane beats needed to send one sample
// ---------------------------------------------------------------------------
package lvds_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        SEND = 2'd2
    } lvds_state_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    function automatic int beats_per_sample(input int sample_w, input int lanes);
        return sample_w / lanes;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO holding DAC samples between the register write path and
// the serialiser. Pushes arriving while full are dropped and flagged.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   push, push_data  : write strobe and sample
//   pop, pop_data    : read strobe; pop_data shows the head sample (show-ahead)
//   full, empty      : occupancy flags, derived from the registered level
//   level            : number of stored samples
//   rejected         : single-cycle pulse, push attempted while full
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             rejected
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    // The head must be usable in the same cycle as the pop, so the read is
    // taken straight from the (small) storage array.
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        // full is judged on the pre-pop occupancy: a push into a full FIFO
        // is rejected even if a pop happens in the same cycle.
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        rejected = push && full;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; only slots behind the write pointer are read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/lvds_tx_streamer.sv
// ---------------------------------------------------------------------------
// lvds_tx_streamer
// Buffers DAC samples, frames each transmit burst with a sync word and
// serialises samples MSB-first across LANES LVDS data lanes.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   tx_en              : transmit enable
//   tone_mode          : 0 = stream (pop per slot), 1 = repeat held sample
//   wr_en, wr_data     : sample push from the register path
//   clr_err            : clears sticky underrun / overflow
//   to_lvds            : registered lane data (lane LANES-1 = higher bit)
//   frame              : high on beat 0 of every slot, sync included
//   busy               : FSM not in IDLE
//   full, empty, level : FIFO status
//   underrun, overflow : sticky error flags
// ---------------------------------------------------------------------------
module lvds_tx_streamer
    import lvds_pkg::*;
#(
    parameter int                  SAMPLE_W  = 8,
    parameter int                  LANES     = 2,
    parameter int                  DEPTH     = 8,
    parameter logic [SAMPLE_W-1:0] SYNC_WORD = SAMPLE_W'(DEFAULT_SYNC_WORD)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tx_en,
    input  logic                         tone_mode,
    input  logic                         wr_en,
    input  logic [SAMPLE_W-1:0]          wr_data,
    input  logic                         clr_err,
    output logic [LANES-1:0]             to_lvds,
    output logic                         frame,
    output logic                         busy,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         underrun,
    output logic                         overflow
);

    localparam int BEATS  = beats_per_sample(SAMPLE_W, LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    lvds_state_t         state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic [SAMPLE_W-1:0] held_q, held_d;
    logic [LANES-1:0]    to_lvds_q, to_lvds_d;
    logic                frame_q, frame_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;

    logic                last_beat;
    logic                load_slot;
    logic                underrun_set;
    logic [SAMPLE_W-1:0] slot_sample;

    logic                fifo_pop;
    logic [SAMPLE_W-1:0] fifo_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;
    logic                fifo_rejected;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .rejected  (fifo_rejected)
    );

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. tx_en only matters at slot boundaries, so a drop and
    // re-assert inside one slot is invisible to the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_en) state_d = SYNC;
            SYNC:    if (last_beat) state_d = SEND;
            SEND:    if (last_beat && !tx_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        // A new slot is fetched on the last beat of sync, and on the last beat
        // of a data slot while transmission continues.
        load_slot    = last_beat && ((state_q == SYNC) || ((state_q == SEND) && tx_en));
        fifo_pop     = load_slot && !fifo_empty;
        underrun_set = load_slot && fifo_empty && !tone_mode;
        if (!fifo_empty) begin
            slot_sample = fifo_data;
        end else if (tone_mode) begin
            slot_sample = held_q;
        end else begin
            slot_sample = '0;
        end

        beat_d    = beat_q;
        shreg_d   = shreg_q;
        held_d    = held_q;
        to_lvds_d = '0;
        frame_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_en) begin
                    shreg_d = SYNC_WORD;
                    beat_d  = '0;
                end
            end
            SYNC, SEND: begin
                to_lvds_d = shreg_q[SAMPLE_W-1 -: LANES];
                frame_d   = (beat_q == '0);
                if (last_beat) begin
                    beat_d  = '0;
                    shreg_d = load_slot ? slot_sample : '0;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    shreg_d = shreg_q << LANES;
                end
            end
            default: begin
                beat_d  = '0;
                shreg_d = '0;
            end
        endcase

        if (fifo_pop) begin
            held_d = fifo_data;
        end

        // Sticky flags: a new event in the same cycle as clr_err wins.
        underrun_d = underrun_set  ? 1'b1 : (clr_err ? 1'b0 : underrun_q);
        overflow_d = fifo_rejected ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q     <= '0;
            shreg_q    <= '0;
            held_q     <= '0;
            to_lvds_q  <= '0;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            shreg_q    <= shreg_d;
            held_q     <= held_d;
            to_lvds_q  <= to_lvds_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign to_lvds  = to_lvds_q;
    assign frame    = frame_q;
    assign busy     = (state_q != IDLE);
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign level    = fifo_level;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule

// File: doc/lvds_tx_streamer.md
# lvds_tx_streamer

Parametrised successor to the single-register DAC transmit FSM. It buffers DAC samples written over the SPI register path in a small FIFO, frames each transmit burst with a sync word, and serialises samples MSB-first across `LANES` LVDS data lanes. It adds a stream/tone mode and sticky underrun/overflow flags. It sits between `regwrap` (DAC register write strobe and data) and the LVDS output pins.

## Interface
Parameters:
- `SAMPLE_W`, 8: sample width in bits. Must be a multiple of `LANES`.
- `LANES`, 2: number of output lanes. `BEATS = SAMPLE_W/LANES` beats per sample.
- `DEPTH`, 8: FIFO depth in samples. Power of two, ≥ 2.
- `SYNC_WORD`, `8'hA5`: preamble sample, `SAMPLE_W` bits wide.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_en`  in  1  transmit enable (DAC control register bit 0).
- `tone_mode`  in  1  0 = stream (pop per sample); 1 = tone (repeat last loaded sample).
- `wr_en`  in  1  push strobe, one sample per cycle.
- `wr_data`  in  `SAMPLE_W`  sample to push.
- `clr_err`  in  1  clears `underrun` and `overflow`.
- `to_lvds`  out  `LANES`  serial lane data, registered.
- `frame`  out  1  high on beat 0 of every sample slot (including sync).
- `busy`  out  1  high in any state other than IDLE.
- `full`  out  1  FIFO full.
- `empty`  out  1  FIFO empty.
- `level`  out  `$clog2(DEPTH+1)`  FIFO occupancy.
- `underrun`  out  1  sticky; stream mode found the FIFO empty at a slot boundary.
- `overflow`  out  1  sticky; a push arrived while the FIFO was full.

## Operation
- Reset values:
  - `to_lvds` = 0, `frame` = 0, `busy` = 0, `full` = 0, `empty` = 1, `level` = 0, `underrun` = 0, `overflow` = 0.
  - FIFO pointers 0, state IDLE, held sample 0.
- FIFO:
  - A push is accepted only if `full` is low, with `full` evaluated before any same-cycle pop. Otherwise the sample is dropped and `overflow` sets.
  - A simultaneous accepted push and pop leaves `level` unchanged.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- State machine:
  - IDLE: `to_lvds` = 0. When `tx_en` = 1, go to SYNC, load the shift register with `SYNC_WORD`, and reset the beat counter.
  - SYNC: shift out `BEATS` beats. On the last beat, load the next slot (slot-load rule below) and go to SEND.
  - SEND: shift out `BEATS` beats per slot. On the last beat:
    - if `tx_en` = 0, go to IDLE;
    - otherwise load the next slot.
- Slot-load rule:
  - Stream mode, FIFO not empty: pop the FIFO and load that sample (it also becomes the held sample).
  - Stream mode, FIFO empty: load all-zero and set `underrun`. The state does not change.
  - Tone mode, FIFO not empty: pop and load as in stream mode.
  - Tone mode, FIFO empty: load the held sample; `underrun` is not set.
- Serialisation: `to_lvds` = `shreg[SAMPLE_W-1 -: LANES]`; then shift left by `LANES`. MSB-first; lane `LANES-1` carries the higher bit.
- `tx_en` deassert mid-slot: the current slot completes, then the block returns to IDLE. A re-assert before the slot ends is ignored, so no new sync is sent.
- `clr_err` together with a new error event in the same cycle: set wins.
- A `tone_mode` change takes effect at the next slot boundary.

## Timing
- Latency:
  - `tx_en` sampled high in IDLE at edge N → first sync beat on `to_lvds`, with `frame` = 1, after edge N+1.
  - The first data beat follows exactly `BEATS` cycles later.
- Throughput: one beat per clock, no gaps between slots. The pop for a slot happens in the same cycle as the last beat of the previous slot.
- Flags:
  - `level`, `full` and `empty` update the cycle after a push or pop.
  - `underrun` and `overflow` assert the cycle after the triggering event.
- `busy` falls the cycle after the final beat of the last slot.

## Structure
- Shared package `lvds_pkg`:
  - state enum `lvds_state_t` {IDLE, SYNC, SEND};
  - default `SYNC_WORD` constant;
  - a `BEATS` helper function.
- Sub-module `sample_fifo`: parametrised synchronous FIFO with push, pop, full, empty, level and overflow-reject. The top level holds the FSM, shift register, beat counter and sticky flags.

## Test plan
All scenarios use the defaults (`SAMPLE_W` = 8, `LANES` = 2).
- Reset mid-SEND → all outputs at their reset values within the same cycle; `empty` = 1.
- Push 0x01, then `tx_en` = 1 → `to_lvds` shows 10,10,01,01 (sync 0xA5), then 00,00,00,01; `frame` is high on beats 0 and 4.
- Stream mode, push 0xC3 only, `tx_en` held → 0xC3 slot, then a zero slot with `underrun` = 1; `clr_err` returns it to 0.
- Tone mode, push 0x5A only → 01,01,10,10 repeats indefinitely; `underrun` stays 0.
- Fill with 8 pushes plus a 9th push → `full` = 1, `level` = 8, `overflow` = 1; the 9th sample is never transmitted.
- Deassert `tx_en` on beat 1 of a slot → beats 2–3 still complete, then IDLE with `to_lvds` = 0 and `busy` = 0.
